// File: rtl/fall_detector_if.sv
// ============================================================================
// fall_detector_if : sample-buffer read port and fall status of fall_detector
// Optional macro: FALL_PEAK_HOLD_EN (adds peak_mag)
// Rev 1.0
// ============================================================================
`default_nettype none

interface fall_detector_if;
  logic        data_ready;
  logic [15:0] rd_data;
  logic [4:0]  rd_index;
  logic        read_done;
  logic        busy;
  logic        fall_clr;
  logic        fall_detected;
  logic        fall_pulse;
`ifdef FALL_PEAK_HOLD_EN
  logic [11:0] peak_mag;

  modport master (
    input  data_ready, rd_data, fall_clr,
    output rd_index, read_done, busy, fall_detected, fall_pulse, peak_mag
  );
  modport slave (
    output data_ready, rd_data, fall_clr,
    input  rd_index, read_done, busy, fall_detected, fall_pulse, peak_mag
  );
`else
  modport master (
    input  data_ready, rd_data, fall_clr,
    output rd_index, read_done, busy, fall_detected, fall_pulse
  );
  modport slave (
    output data_ready, rd_data, fall_clr,
    input  rd_index, read_done, busy, fall_detected, fall_pulse
  );
`endif
endinterface

`default_nettype wire

// File: rtl/fall_detector.sv
// ============================================================================
// fall_detector : reads a 32-sample Z-axis buffer, detects free-fall + impact
// Optional macro: FALL_PEAK_HOLD_EN (peak magnitude hold)       Rev 1.0
// ============================================================================
`default_nettype none

module fall_detector #(
  parameter int FF_TH     = 300,
  parameter int IMPACT_TH = 1800,
  parameter int FF_MIN    = 8,
  parameter int WINDOW    = 100
) (
  input  wire logic       sys_clk,
  input  wire logic       sys_rst,
  fall_detector_if.master bus
);

  localparam logic [11:0] C_FF_TH     = 12'(FF_TH);
  localparam logic [11:0] C_IMPACT_TH = 12'(IMPACT_TH);
  localparam logic [7:0]  C_FF_MIN    = 8'(FF_MIN);
  localparam logic [15:0] C_WINDOW    = 16'(WINDOW);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_EVAL    = 3'd2,
    S_RELEASE = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t      state_q;
  logic [4:0]  rd_index_q;
  logic        read_done_q, busy_q, fall_detected_q, fall_pulse_q;
  logic [7:0]  ff_cnt_q, ff_cnt_d;
  logic        armed_q, armed_d;
  logic [15:0] win_cnt_q, win_cnt_d;

  logic [11:0] sample_w, mag_w;
  logic [7:0]  ff_inc_w;
  logic        detect_w;
  logic        unused_lsbs_w;

  assign unused_lsbs_w = ^bus.rd_data[3:0];

  // Two's-complement magnitude fits 12 unsigned bits, so -2048 maps to 2048.
  always_comb begin
    sample_w  = bus.rd_data[15:4];
    mag_w     = sample_w[11] ? (~sample_w + 12'd1) : sample_w;
    ff_inc_w  = (ff_cnt_q == C_FF_MIN) ? ff_cnt_q : ff_cnt_q + 8'd1;
    ff_cnt_d  = ff_cnt_q;
    armed_d   = armed_q;
    win_cnt_d = win_cnt_q;
    detect_w  = 1'b0;
    if (armed_q && (mag_w > C_IMPACT_TH)) begin
      detect_w  = 1'b1;
      armed_d   = 1'b0;
      ff_cnt_d  = 8'd0;
      win_cnt_d = 16'd0;
    end else if (mag_w < C_FF_TH) begin
      ff_cnt_d = ff_inc_w;
      if (ff_inc_w == C_FF_MIN) begin
        armed_d   = 1'b1;
        win_cnt_d = C_WINDOW;
      end
    end else begin
      ff_cnt_d = 8'd0;
      if (armed_q) begin
        win_cnt_d = win_cnt_q - 16'd1;
        if (win_cnt_q == 16'd1) armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q         <= S_IDLE;
      rd_index_q      <= 5'd31;
      read_done_q     <= 1'b0;
      busy_q          <= 1'b0;
      fall_detected_q <= 1'b0;
      fall_pulse_q    <= 1'b0;
      ff_cnt_q        <= 8'd0;
      armed_q         <= 1'b0;
      win_cnt_q       <= 16'd0;
    end else begin
      read_done_q  <= 1'b0;
      fall_pulse_q <= 1'b0;
      if (bus.fall_clr) fall_detected_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.data_ready) begin
            state_q    <= S_ADDR;
            rd_index_q <= 5'd31;
            busy_q     <= 1'b1;
          end
        end
        S_ADDR: state_q <= S_EVAL;
        S_EVAL: begin
          ff_cnt_q  <= ff_cnt_d;
          armed_q   <= armed_d;
          win_cnt_q <= win_cnt_d;
          if (detect_w) begin
            fall_pulse_q    <= 1'b1;
            fall_detected_q <= 1'b1;
          end
          if (rd_index_q == 5'd0) begin
            state_q     <= S_RELEASE;
            read_done_q <= 1'b1;
          end else begin
            rd_index_q <= rd_index_q - 5'd1;
            state_q    <= S_ADDR;
          end
        end
        S_RELEASE: begin
          rd_index_q <= 5'd31;
          state_q    <= S_DROP;
        end
        S_DROP: begin
          // The poller keeps data_ready up until it sees read_done; wait it out.
          if (!bus.data_ready) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_index      = rd_index_q;
  assign bus.read_done     = read_done_q;
  assign bus.busy          = busy_q;
  assign bus.fall_detected = fall_detected_q;
  assign bus.fall_pulse    = fall_pulse_q;

`ifdef FALL_PEAK_HOLD_EN
  logic [11:0] track_q, peak_q, peak_max_w;

  assign peak_max_w = (mag_w > track_q) ? mag_w : track_q;

  // Track runs only while armed; a new arming starts from the arming sample.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      track_q <= 12'd0;
      peak_q  <= 12'd0;
    end else begin
      if (state_q == S_EVAL) begin
        track_q <= armed_d ? (armed_q ? peak_max_w : mag_w) : 12'd0;
      end
      if ((state_q == S_EVAL) && detect_w) begin
        peak_q <= peak_max_w;
      end else if (bus.fall_clr) begin
        peak_q <= 12'd0;
      end
    end
  end

  assign bus.peak_mag = peak_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fall_detector.sv
// ============================================================================
// tb_fall_detector : directed and randomized buffers against a sample-stream model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fall_detector;

  localparam int FF_TH     = 300;
  localparam int IMPACT_TH = 1800;
  localparam int FF_MIN    = 8;
  localparam int WINDOW    = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] mem [32];
  logic [15:0] stream [$];

  int total = 0;
  int bad   = 0;

  // reference model state: free-fall run length, armed flag, non-free-fall samples since arming
  int run_len   = 0;
  int since_arm = 0;
  bit armed_m   = 1'b0;
  bit flag_m    = 1'b0;

  fall_detector_if bif ();

  fall_detector #(
    .FF_TH    (FF_TH),
    .IMPACT_TH(IMPACT_TH),
    .FF_MIN   (FF_MIN),
    .WINDOW   (WINDOW)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bif)
  );

  always #5 sys_clk = ~sys_clk;

  assign bif.rd_data = mem[bif.rd_index];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_step(input logic [15:0] w);
    int  sv;
    int  mag;
    bit  det;
    det = 1'b0;
    sv  = int'($signed(w[15:4]));
    mag = (sv < 0) ? -sv : sv;
    if (armed_m && mag > IMPACT_TH) begin
      det     = 1'b1;
      armed_m = 1'b0;
      run_len = 0;
    end else if (mag < FF_TH) begin
      run_len++;
      if (run_len >= FF_MIN) begin
        armed_m   = 1'b1;
        since_arm = 0;
      end
    end else begin
      run_len = 0;
      if (armed_m) begin
        since_arm++;
        if (since_arm >= WINDOW) armed_m = 1'b0;
      end
    end
    return det;
  endfunction

  task automatic push_n(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) stream.push_back(w);
  endtask

  task automatic pad();
    while (stream.size() % 32 != 0) stream.push_back(16'h4000);
  endtask

  task automatic push_random_batch();
    int n;
    int kind;
    int len;
    int s;
    n = 0;
    while (n < 32) begin
      kind = $urandom_range(0, 9);
      if (kind < 5)      len = $urandom_range(1, 11);
      else if (kind < 8) len = $urandom_range(1, 5);
      else               len = 1;
      for (int j = 0; j < len && n < 32; j++) begin
        if (kind < 5)      s = $urandom_range(0, FF_TH - 1);
        else if (kind < 8) s = $urandom_range(FF_TH, IMPACT_TH);
        else               s = ($urandom_range(0, 3) == 0) ? 2048 : $urandom_range(IMPACT_TH + 1, 2047);
        if (s == 2048)                   s = -2048;
        else if ($urandom_range(0, 1) == 1) s = -s;
        stream.push_back({12'(s), 4'($urandom_range(0, 15))});
        n++;
      end
    end
  endtask

  task automatic clear_flag();
    bif.fall_clr = 1'b1;
    tick();
    bif.fall_clr = 1'b0;
    flag_m = 1'b0;
    check("clr_flag", 32'(bif.fall_detected), 32'(flag_m));
  endtask

  // Observation n is taken just after clock edge n-1, edge 0 being the IDLE edge.
  task automatic run_batch(input int clr_k, input bit drop_early, input int abort_n);
    int  e;
    int  k;
    bit  is_eval;
    bit  exp_p;
    for (int i = 0; i < 32; i++) mem[31 - i] = stream.pop_front();
    bif.data_ready = 1'b1;
    tick();
    check("busy_start", 32'(bif.busy), 32'd1);
    for (int n = 2; n <= 66; n++) begin
      if (n == abort_n) begin
        check("pre_rst_flag", 32'(bif.fall_detected), 32'(flag_m));
        sys_rst = 1'b1;
        #1;
        check("rst_rd_index",  32'(bif.rd_index),      32'd31);
        check("rst_read_done", 32'(bif.read_done),     32'd0);
        check("rst_busy",      32'(bif.busy),          32'd0);
        check("rst_flag",      32'(bif.fall_detected), 32'd0);
        check("rst_pulse",     32'(bif.fall_pulse),    32'd0);
        run_len = 0; since_arm = 0; armed_m = 1'b0; flag_m = 1'b0;
        bif.data_ready = 1'b0;
        tick();
        sys_rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check("post_rst_read_done", 32'(bif.read_done), 32'd0);
          check("post_rst_busy",      32'(bif.busy),      32'd0);
        end
        return;
      end
      e       = n - 1;
      is_eval = (e >= 2) && (e <= 64) && (e % 2 == 0);
      k       = (64 - e) / 2;
      if (is_eval && k == clr_k) bif.fall_clr = 1'b1;
      if (drop_early && n == 20) bif.data_ready = 1'b0;
      tick();
      bif.fall_clr = 1'b0;
      exp_p = 1'b0;
      if (is_eval) begin
        if (k == clr_k) flag_m = 1'b0;
        exp_p = model_step(mem[k]);
        if (exp_p) flag_m = 1'b1;
      end
      check("read_done", 32'(bif.read_done),     32'(n == 65));
      check("fall_pulse", 32'(bif.fall_pulse),   32'(exp_p));
      check("fall_flag", 32'(bif.fall_detected), 32'(flag_m));
    end
    if (!drop_early) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        check("drop_hold_busy", 32'(bif.busy),      32'd1);
        check("drop_hold_rd",   32'(bif.read_done), 32'd0);
      end
      bif.data_ready = 1'b0;
    end
    tick();
    check("idle_busy",     32'(bif.busy),     32'd0);
    check("idle_rd_index", 32'(bif.rd_index), 32'd31);
  endtask

  task automatic run_all();
    while (stream.size() > 0) run_batch(-1, 1'b0, 0);
  endtask

  initial begin
    sys_rst        = 1'b1;
    bif.data_ready = 1'b0;
    bif.fall_clr   = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    tick();
    tick();
    check("reset_rd_index",  32'(bif.rd_index),      32'd31);
    check("reset_read_done", 32'(bif.read_done),     32'd0);
    check("reset_busy",      32'(bif.busy),          32'd0);
    check("reset_flag",      32'(bif.fall_detected), 32'd0);
    check("reset_pulse",     32'(bif.fall_pulse),    32'd0);
    sys_rst = 1'b0;
    tick();

    push_n(16'h4000, 32);
    run_all();
    check("quiet_flag", 32'(bif.fall_detected), 32'd0);

    push_n(16'h0000, 8); push_n(16'h7FF0, 1); pad();
    run_all();
    check("basic_detect", 32'(bif.fall_detected), 32'd1);
    clear_flag();

    push_n(16'h0000, 7); push_n(16'h7FF0, 1); pad();
    run_all();
    check("ff7_nodetect", 32'(bif.fall_detected), 32'd0);

    push_n(16'h0000, 8); push_n(16'h4000, 100); push_n(16'h7FF0, 1); pad();
    run_all();
    check("win100_nodetect", 32'(bif.fall_detected), 32'd0);

    push_n(16'h0000, 8); push_n(16'h4000, 99); push_n(16'h7FF0, 1); pad();
    run_all();
    check("win99_detect", 32'(bif.fall_detected), 32'd1);
    clear_flag();

    push_n(16'h0000, 8); push_n(16'h8000, 1); pad();
    run_all();
    check("neg2048_detect", 32'(bif.fall_detected), 32'd1);
    clear_flag();

    push_n(16'h4000, 28); push_n(16'h0000, 8); push_n(16'h7FF0, 1); pad();
    run_all();
    check("straddle_detect", 32'(bif.fall_detected), 32'd1);
    clear_flag();

    push_n(16'h0000, 8); push_n(16'h7FF0, 1); pad();
    run_batch(23, 1'b0, 0);
    check("clr_vs_detect", 32'(bif.fall_detected), 32'd1);
    clear_flag();

    push_n(16'h0000, 8); push_n(16'h7FF0, 1); pad();
    run_batch(-1, 1'b0, 44);

    for (int b = 0; b < 12; b++) begin
      push_random_batch();
      run_batch(-1, (b == 3), 0);
      if (b % 4 == 2) clear_flag();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
